seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 SHALL have parameter PATTERN, default 4'b1101: bit pattern transmitted MSB first.
REQ-002 SHALL have parameter PLEN, default 4: pattern length in bits, legal range 2..16.
REQ-003 SHALL have parameter GAP, default 1: idle cycles (out=0, valid=0) between repetitions, legal range 0..7.
REQ-004 SHALL have parameter OVL, default 1: leading bits skipped on repetitions 2..N in overlap mode, legal range 0..PLEN-1.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on falling edge.
REQ-006 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-007 SHALL have port start  input  1: request to transmit, sampled at clock edge.
REQ-008 SHALL have port count  input  4: number of pattern repetitions, latched on accepted start.
REQ-009 SHALL have port abort  input  1: synchronous cancel of an in-progress frame.
REQ-010 SHALL have port out  output  1: serial data bit.
REQ-011 SHALL have port valid  output  1: out carries a pattern bit this cycle.
REQ-012 SHALL have port busy  output  1: frame in progress.
REQ-013 SHALL have port done  output  1: one-cycle pulse, frame completed normally.

Function
REQ-014 SHALL be a Moore machine: out, valid, busy, done decoded from registered state and shift register only, never combinationally from inputs.
REQ-015 SHALL implement states IDLE, SHIFT, GAP, DONE.
REQ-016 SHALL accept start only in IDLE or DONE; start in SHIFT or GAP ignored, count not re-latched.
REQ-017 Accepted start with count!=0 SHALL enter SHIFT; first bit (PATTERN[PLEN-1]) on out in the cycle after the sampling edge.
REQ-018 Accepted start with count==0 SHALL enter DONE directly; valid never asserted for that frame.
REQ-019 SHIFT SHALL emit one bit per cycle MSB first with valid=1, busy=1.
REQ-020 After last bit of a repetition with repetitions remaining, SHALL go to GAP for exactly GAP cycles (skip GAP when GAP=0), then SHIFT reloaded with PATTERN.
REQ-021 After last bit of last repetition SHALL enter DONE for exactly one cycle: done=1, busy=0, valid=0, out=0; then IDLE unless start accepted.
REQ-022 In IDLE, GAP, DONE: out=0, valid=0; busy=1 in GAP only.
REQ-023 Non-overlap frame length SHALL be count*PLEN + (count-1)*GAP bit cycles from first bit to last.
REQ-024 abort in SHIFT or GAP SHALL force IDLE at next edge: out=0, valid=0, busy=0, no done pulse; abort in IDLE/DONE has no effect.
REQ-025 abort and start asserted together SHALL resolve as abort (start dropped).
REQ-026 Repetition counter SHALL be 4 bits, decrement once per completed repetition, no wrap (count=15 yields exactly 15 repetitions).

Reset
REQ-027 reset high at a clock edge SHALL force IDLE, out=0, valid=0, busy=0, done=0, counters and shift register cleared, regardless of start/abort.
REQ-028 reset mid-frame SHALL abandon the frame without a done pulse.

Configuration
REQ-029 Macro SEQ_TX_OVERLAP_EN defined: repetitions 2..N SHALL emit only PATTERN[PLEN-1-OVL:0] back-to-back with no GAP cycles; length = PLEN + (count-1)*(PLEN-OVL).
REQ-030 Macro SEQ_TX_OVERLAP_EN undefined: every repetition SHALL emit full PATTERN with GAP cycles per REQ-020; OVL ignored.

Verification
REQ-031 Defaults, no macro, count=1, start pulse -> out 1,1,0,1 with valid=1 in cycles 1-4, done=1 in cycle 5 only.
REQ-032 No macro, count=2 -> out 1,1,0,1,0,1,1,0,1, valid 1,1,1,1,0,1,1,1,1, busy high all 9 cycles, done in cycle 10.
REQ-033 SEQ_TX_OVERLAP_EN, count=2 -> out 1,1,0,1,1,0,1 contiguous valid; an overlapping 1101 Moore detector fed with this stream reports 2 detections.
REQ-034 count=0, start -> done=1 next cycle, valid=0 and busy=0 throughout.
REQ-035 count=3, abort during 2nd bit of 2nd repetition -> next cycle out=0, valid=0, busy=0, no done; new start then produces full frame.
REQ-036 reset asserted with start in same cycle mid-frame -> all outputs 0 next cycle, state IDLE; start in the following cycle with count=1 gives 1,1,0,1.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Repeating serial pattern transmitter (Moore FSM, falling-edge state).
// Optional SEQ_TX_OVERLAP_EN: later repetitions skip OVL leading bits, no gaps.
module seq_pattern_tx #(
  parameter logic [15:0] PATTERN = 4'b1101,
  parameter int          PLEN    = 4,
  parameter int          GAP     = 1,
  parameter int          OVL     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] count,
  input  logic       abort,
  output logic       out,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAPS  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [PLEN-1:0] PAT = PATTERN[PLEN-1:0];
  localparam logic [3:0] LAST  = 4'(PLEN - 1);
  localparam logic [2:0] GLAST = 3'(GAP - 1);
`ifdef SEQ_TX_OVERLAP_EN
  localparam logic [PLEN-1:0] OPAT = PAT << OVL;
  localparam logic [3:0] OLAST = 4'(PLEN - 1 - OVL);
`endif

  logic [1:0]      state;
  logic [PLEN-1:0] sr;
  logic [3:0]      bcnt;
  logic [3:0]      rep;
  logic [2:0]      gcnt;

  logic st_idle, st_shift, st_gap, st_done;
  logic go;

  assign st_idle  = (state == IDLE);
  assign st_shift = (state == SHIFT);
  assign st_gap   = (state == GAPS);
  assign st_done  = (state == DONE);
  assign go       = start & ~abort;

  assign out   = st_shift & sr[PLEN-1];
  assign valid = st_shift;
  assign busy  = st_shift | st_gap;
  assign done  = st_done;

  always_ff @(negedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      bcnt  <= '0;
      rep   <= '0;
      gcnt  <= '0;
    end else begin
      unique case (1'b1)
        st_idle, st_done: begin
          if (go && count == 4'd0) begin
            state <= DONE;
          end else if (go) begin
            state <= SHIFT;
            sr    <= PAT;
            bcnt  <= LAST;
            rep   <= count;
          end else begin
            state <= IDLE;
          end
        end
        st_shift: begin
          if (abort) begin
            state <= IDLE;
            sr    <= '0;
            bcnt  <= '0;
            rep   <= '0;
          end else if (bcnt != 4'd0) begin
            sr   <= sr << 1;
            bcnt <= bcnt - 4'd1;
          end else if (rep == 4'd1) begin
            state <= DONE;
            sr    <= '0;
            rep   <= '0;
          end else begin
            rep <= rep - 4'd1;
`ifdef SEQ_TX_OVERLAP_EN
            sr   <= OPAT;
            bcnt <= OLAST;
`else
            if (GAP == 0) begin
              sr   <= PAT;
              bcnt <= LAST;
            end else begin
              state <= GAPS;
              sr    <= '0;
              gcnt  <= GLAST;
            end
`endif
          end
        end
        st_gap: begin
          if (abort) begin
            state <= IDLE;
            rep   <= '0;
            gcnt  <= '0;
          end else if (gcnt == 3'd0) begin
            state <= SHIFT;
            sr    <= PAT;
            bcnt  <= LAST;
          end else begin
            gcnt <= gcnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with default parameters.
// Outputs sampled 1 time unit after the falling (active) edge.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] count = 4'd0;
  logic       abort = 1'b0;
  logic       out, valid, busy, done;

  int checks = 0;
  int failures = 0;

  seq_pattern_tx dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .count (count),
    .abort (abort),
    .out   (out),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    count = 4'd1;
    step();
    step();
    start = 1'b0;
    checks++;
    if ({out, valid, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0000",
               {out, valid, busy, done});
    end
    reset = 1'b0;
    step();
    checks++;
    if ({out, valid, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0000",
               {out, valid, busy, done});
    end
  endtask

  task automatic test_single();
    logic [3:0] pat;
    pat = 4'b1101;
    count = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out, valid, busy, done} !== {pat[3-i], 3'b110}) begin
        failures++;
        $display("FAIL single_c%0d got=%b exp=%b", i + 1,
                 {out, valid, busy, done}, {pat[3-i], 3'b110});
      end
      step();
    end
    checks++;
    if ({out, valid, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL single_done got=%b exp=0001",
               {out, valid, busy, done});
    end
    step();
    checks++;
    if ({out, valid, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL single_after got=%b exp=0000",
               {out, valid, busy, done});
    end
  endtask

  task automatic test_two_reps();
`ifdef SEQ_TX_OVERLAP_EN
    localparam int N = 7;
    logic [N-1:0] eo = 7'b1101101;
    logic [N-1:0] ev = 7'b1111111;
`else
    localparam int N = 9;
    logic [N-1:0] eo = 9'b110101101;
    logic [N-1:0] ev = 9'b111101111;
`endif
    logic [3:0] win;
    int det;
    win = 4'b0;
    det = 0;
    count = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({out, valid, busy, done} !==
          {eo[N-1-i], ev[N-1-i], 2'b10}) begin
        failures++;
        $display("FAIL two_c%0d got=%b exp=%b", i + 1,
                 {out, valid, busy, done},
                 {eo[N-1-i], ev[N-1-i], 2'b10});
      end
      if (valid) begin
        win = {win[2:0], out};
        if (win == 4'b1101) det++;
      end
      step();
    end
    checks++;
    if ({out, valid, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL two_done got=%b exp=0001",
               {out, valid, busy, done});
    end
    checks++;
    if (det !== 2) begin
      failures++;
      $display("FAIL two_detect got=%0d exp=2", det);
    end
    step();
  endtask

  task automatic test_zero();
    count = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({out, valid, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL zero_done got=%b exp=0001",
               {out, valid, busy, done});
    end
    step();
    checks++;
    if ({out, valid, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL zero_after got=%b exp=0000",
               {out, valid, busy, done});
    end
  endtask

  task automatic test_abort();
`ifdef SEQ_TX_OVERLAP_EN
    localparam int ADV = 5;
    localparam logic EB = 1'b0;
`else
    localparam int ADV = 6;
    localparam logic EB = 1'b1;
`endif
    logic [3:0] pat;
    int sawdone;
    pat = 4'b1101;
    sawdone = 0;
    count = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < ADV; i++) step();
    checks++;
    if ({out, valid, busy, done} !== {EB, 3'b110}) begin
      failures++;
      $display("FAIL abort_pre got=%b exp=%b",
               {out, valid, busy, done}, {EB, 3'b110});
    end
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if ({out, valid, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_post got=%b exp=0000",
               {out, valid, busy, done});
    end
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) sawdone++;
    end
    checks++;
    if (sawdone !== 0) begin
      failures++;
      $display("FAIL abort_quiet got=%0d exp=0", sawdone);
    end
    count = 4'd1;
    start = 1'b1;
    step();
    start = 1'b1;
    count = 4'd0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out, valid, busy, done} !== {pat[3-i], 3'b110}) begin
        failures++;
        $display("FAIL abort_new_c%0d got=%b exp=%b", i + 1,
                 {out, valid, busy, done}, {pat[3-i], 3'b110});
      end
      step();
      start = 1'b0;
    end
    checks++;
    if ({out, valid, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL abort_new_done got=%b exp=0001",
               {out, valid, busy, done});
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [3:0] pat;
    pat = 4'b1101;
    count = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if ({out, valid, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_outs got=%b exp=0000",
               {out, valid, busy, done});
    end
    count = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out, valid, busy, done} !== {pat[3-i], 3'b110}) begin
        failures++;
        $display("FAIL rstmid_c%0d got=%b exp=%b", i + 1,
                 {out, valid, busy, done}, {pat[3-i], 3'b110});
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_done got=%b exp=1", done);
    end
    step();
  endtask

  task automatic test_count15();
`ifdef SEQ_TX_OVERLAP_EN
    localparam int EV = 46;
    localparam int EB = 46;
`else
    localparam int EV = 60;
    localparam int EB = 74;
`endif
    int nv, nb, got;
    nv = 0;
    nb = 0;
    got = 0;
    count = 4'd15;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      if (valid) nv++;
      if (busy) nb++;
      if (done) got = 1;
      else step();
    end
    checks++;
    if (got !== 1) begin
      failures++;
      $display("FAIL c15_done got=%0d exp=1", got);
    end
    checks++;
    if (nv !== EV) begin
      failures++;
      $display("FAIL c15_valid got=%0d exp=%0d", nv, EV);
    end
    checks++;
    if (nb !== EB) begin
      failures++;
      $display("FAIL c15_busy got=%0d exp=%0d", nb, EB);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_reps();
    test_zero();
    test_abort();
    test_reset_mid();
    test_count15();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
